dac_share_scheduler: RTL

- Time-multiplexes one 4-bit resistor-ladder DAC (dac4x1 path: 16-tap voltage divider plus 16:1 mux) between NUM_CH requesting channels.
- Round-robin arbitration selects one channel. The block loads that channel's code onto the DAC and waits a programmable settling interval.
- It then pulses a sample/hold strobe and acknowledges the channel.
- Sits between channel logic and the dac4x1 `in` input. Downstream sample-and-hold capture uses hold_strobe.

---
 rtl/dac_share_scheduler_if.sv | 25 ++
 rtl/dac_share_scheduler.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/dac_share_scheduler_if.sv
// rtl/dac_share_scheduler_if.sv - channel-side bus of the shared DAC scheduler
interface dac_share_scheduler_if #(
  parameter int NUM_CH = 4
);
  logic                  en;
  logic [NUM_CH-1:0]     req;
  logic [4*NUM_CH-1:0]   req_code;
  logic [3:0]            dac_code;
  logic                  hold_strobe;
  logic [NUM_CH-1:0]     ack;
  logic [2:0]            active_ch;
  logic                  busy;

  // channel logic side
  modport master (
    output en, req, req_code,
    input  dac_code, hold_strobe, ack, active_ch, busy
  );

  // scheduler side
  modport slave (
    input  en, req, req_code,
    output dac_code, hold_strobe, ack, active_ch, busy
  );
endinterface

// File: rtl/dac_share_scheduler.sv
// rtl/dac_share_scheduler.sv - round-robin time-multiplexing of one 4-bit ladder DAC
module dac_share_scheduler #(
  parameter int NUM_CH     = 4,
  parameter int SETTLE_CYC = 4,
  parameter int SKIP_SAME  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  dac_share_scheduler_if.slave  bus
);

  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, STROBE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [3:0]          dac_code_q, dac_code_d;
  logic                hold_strobe_q, hold_strobe_d;
  logic [NUM_CH-1:0]   ack_q, ack_d;
  logic [2:0]          active_ch_q, active_ch_d;
  logic                busy_q, busy_d;
  logic [2:0]          rr_ptr_q, rr_ptr_d;
  logic [NUM_CH-1:0]   mask_q, mask_d;

  logic [NUM_CH-1:0]   eff_req;
  logic [NUM_CH-1:0]   rot_req;
  logic [4*NUM_CH-1:0] rot_code;
  logic                win_any;
  logic [2:0]          win_off;
  logic [3:0]          win_code;
  logic [3:0]          win_sum;
  logic [2:0]          win_idx;
  logic [2:0]          next_ptr;

  // Round-robin pick: rotate requests so rr_ptr sits at bit 0, take the lowest set bit.
  always_comb begin
    eff_req  = bus.req & ~mask_q;
    rot_req  = NUM_CH'({eff_req, eff_req} >> rr_ptr_q);
    rot_code = (4*NUM_CH)'({bus.req_code, bus.req_code} >> {rr_ptr_q, 2'b00});
    win_any  = |eff_req;
    win_off  = '0;
    win_code = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (rot_req[i]) begin
        win_off  = 3'(i);
        win_code = rot_code[4*i +: 4];
      end
    end
    win_sum = {1'b0, rr_ptr_q} + {1'b0, win_off};
    if (win_sum >= 4'(NUM_CH)) begin
      win_sum = win_sum - 4'(NUM_CH);
    end
    win_idx  = win_sum[2:0];
    next_ptr = (active_ch_q == 3'(NUM_CH - 1)) ? 3'd0 : active_ch_q + 3'd1;
  end

  // Next-state and next-output computation for the IDLE/SETTLE/STROBE sequence.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    dac_code_d    = dac_code_q;
    hold_strobe_d = hold_strobe_q;
    ack_d         = ack_q;
    active_ch_d   = active_ch_q;
    busy_d        = busy_q;
    rr_ptr_d      = rr_ptr_q;
    mask_d        = mask_q;
    case (state_q)
      IDLE: begin
        // The just-acked channel is only ignored for a single IDLE cycle.
        mask_d = '0;
        if (bus.en && win_any) begin
          dac_code_d  = win_code;
          active_ch_d = win_idx;
          cnt_d       = CNT_INIT;
          busy_d      = 1'b1;
          if ((SKIP_SAME != 0) && (win_code == dac_code_q)) begin
            state_d       = STROBE;
            hold_strobe_d = 1'b1;
            ack_d         = NUM_CH'(1) << win_idx;
          end else begin
            state_d = SETTLE;
          end
        end
      end
      SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d       = STROBE;
          hold_strobe_d = 1'b1;
          ack_d         = NUM_CH'(1) << active_ch_q;
        end
      end
      STROBE: begin
        state_d       = IDLE;
        hold_strobe_d = 1'b0;
        ack_d         = '0;
        busy_d        = 1'b0;
        rr_ptr_d      = next_ptr;
        mask_d        = ack_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transfer without an ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      dac_code_q    <= '0;
      hold_strobe_q <= 1'b0;
      ack_q         <= '0;
      active_ch_q   <= '0;
      busy_q        <= 1'b0;
      rr_ptr_q      <= '0;
      mask_q        <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      dac_code_q    <= dac_code_d;
      hold_strobe_q <= hold_strobe_d;
      ack_q         <= ack_d;
      active_ch_q   <= active_ch_d;
      busy_q        <= busy_d;
      rr_ptr_q      <= rr_ptr_d;
      mask_q        <= mask_d;
    end
  end

  assign bus.dac_code    = dac_code_q;
  assign bus.hold_strobe = hold_strobe_q;
  assign bus.ack         = ack_q;
  assign bus.active_ch   = active_ch_q;
  assign bus.busy        = busy_q;

endmodule
